// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program counter, IDLE/RUN/HALT sequencing and jump-target LUT.
// Latency: pc/taken/done update one cycle after inputs are sampled; LUT read is combinational.
// Optional build macro TAKEN_CNT_EN adds a saturating taken_cnt redirect counter output.
module fetch_ctrl #(
  parameter int PC_W       = 10,
  parameter int LUT_AW     = 5,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              br_op,
  input  logic              Jen,
  input  logic              Brc_J,
  input  logic [LUT_AW-1:0] lut_idx,
  input  logic              halt_op,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
`ifdef TAKEN_CNT_EN
  output logic [15:0]       taken_cnt,
`endif
  output logic [PC_W-1:0]   pc,
  output logic              taken,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              taken_q, taken_d;
  logic              done_q, done_d;
  logic              redir;
  logic              count_redir;
  logic [PC_W-1:0]   lut_rdata;

  // Target table is never reset; contents survive a core reset.
  logic [PC_W-1:0]   lut_q [2**LUT_AW];

  // Brc_J is active-low: a cleared bit means the branch condition held.
  assign redir     = Jen | (br_op & ~Brc_J);
  // Combinational read sees the pre-edge contents, so a same-cycle write returns the old value.
  assign lut_rdata = lut_q[lut_idx];

  // LUT write port, usable in every state including reset.
  always_ff @(posedge clk) begin
    if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  // State, pc and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      taken_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-pc selection; in RUN halt beats stall beats redirect beats increment.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    taken_d     = 1'b0;
    done_d      = done_q;
    count_redir = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = PC_W'(START_ADDR);
        end
      end
      RUN: begin
        if (halt_op) begin
          state_d = HALT;
          done_d  = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (redir) begin
          pc_d        = lut_rdata;
          taken_d     = 1'b1;
          count_redir = 1'b1;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      HALT: begin
        pc_d = pc_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef TAKEN_CNT_EN
  logic [15:0] taken_cnt_q;

  // Redirect counter: cleared by reset or by the start that launches RUN, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      taken_cnt_q <= '0;
    end else if (count_redir && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_q <= taken_cnt_q + 16'd1;
    end
  end

  assign taken_cnt = taken_cnt_q;
`endif

  assign pc    = pc_q;
  assign taken = taken_q;
  assign done  = done_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Program-counter and next-address unit for the 8-bit core; it is the consumer end of the ALU's branch/jump outputs (Jen, Brc_J).
- Each cycle it holds the PC, then advances it, redirects it through a jump-target LUT, stalls, or halts.
- Sits between instruction ROM addressing and the ALU/control path.
- Sequential: PC register, IDLE/RUN/HALT FSM, writable target LUT.

Parameters:
- PC_W, 10, program counter width in bits.
- LUT_AW, 5, target-LUT address width; the LUT has 2**LUT_AW entries of PC_W bits.
- START_ADDR, 0, PC value loaded on start.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; IDLE→RUN, PC←START_ADDR
- stall  in  1  hold PC this cycle (RUN only)
- br_op  in  1  current instruction is a conditional branch (blt/beq class)
- Jen  in  1  ALU unconditional-jump enable
- Brc_J  in  1  ALU branch result, active-low: 0 = condition met
- lut_idx  in  LUT_AW  target-LUT index from the instruction field
- halt_op  in  1  current instruction is the done/halt instruction
- lut_we  in  1  LUT write enable
- lut_waddr  in  LUT_AW  LUT write address
- lut_wdata  in  PC_W  LUT write data
- pc  out  PC_W  current instruction address
- taken  out  1  registered; redirect occurred on the previous cycle
- done  out  1  high while in HALT

Behaviour:
- Reset (synchronous, highest priority):
  - state←IDLE, pc←0, taken←0, done←0.
  - LUT contents are not cleared.
  - Reset asserted mid-RUN aborts immediately on that edge.
- IDLE:
  - pc holds.
  - start=1 → RUN, pc←START_ADDR.
  - All other inputs except the LUT write port are ignored.
- RUN: a redirect is required when redir = Jen | (br_op & ~Brc_J). Priority at each edge, highest first:
  1. halt_op=1 → HALT, pc holds, done←1 on the same edge.
  2. stall=1 → pc holds, taken←0.
  3. redir=1 → pc←LUT[lut_idx], taken←1.
  4. Otherwise → pc←pc+1 (mod 2**PC_W, wraps to 0), taken←0.
- Signals ignored when the redirect condition is false:
  - Brc_J when br_op=0 and Jen=0.
  - lut_idx when there is no redirect.
- HALT:
  - pc and done hold until reset; start is ignored.
  - Leaving HALT requires reset, then start.
- LUT:
  - Synchronous write on lut_we at any state.
  - Asynchronous read.
  - Simultaneous write and read of the same index in one cycle: the read returns the OLD value; the new value is visible from the next cycle.
- Latency:
  - pc updates one cycle after the inputs are sampled.
  - taken is aligned with the new pc.
- start while in RUN: ignored.

Optional Feature:
- Macro: TAKEN_CNT_EN.
- Defined:
  - Adds output taken_cnt [15:0], which counts redirects taken in RUN.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by start.
  - Stalled cycles and halt cycles do not count.
- Undefined: no port, no counter logic; all other behaviour is identical.

Test Plan:
- Reset, then start pulse, then 5 idle cycles → pc sequence 0,1,2,3,4,5; taken=0 throughout; done=0.
- Write LUT[3]=10'h2A0, then drive Jen=1 with lut_idx=3 at pc=7 → next pc=0x2A0, taken=1 for one cycle, then pc=0x2A1.
- Drive br_op=1 with Brc_J=1 → pc increments. Drive br_op=1 with Brc_J=0 and lut_idx=3 → pc=0x2A0.
- stall=1 together with Jen=1 → pc holds and taken=0; drop stall → redirect occurs the next cycle.
- Set pc=10'h3FF with no redirect → pc wraps to 0.
- halt_op=1 at pc=12 → done=1 and pc stays 12 for 10 cycles despite start pulses.
- Reset mid-HALT → IDLE with pc=0 and done=0.
- TAKEN_CNT_EN build: 3 redirects plus 1 stalled jump → taken_cnt=3. A start pulse clears taken_cnt to 0.
